// File: rtl/spgd_adc_integrator.sv
// spgd_adc_integrator: ADC-side responder to the SPGD ADC_EN/ADC_DONE handshake.
// Discards a settling window, integrates 2^SAMPLE_LOG2 samples, then holds the result.
module spgd_adc_integrator #(
  parameter int ADC_WIDTH     = 14,
  parameter int ACC_WIDTH     = 32,
  parameter int SETTLE_CYCLES = 10,
  parameter int SAMPLE_LOG2   = 10
) (
  input  logic                 ADC_CLK,
  input  logic                 ADC_RSTN,
  input  logic                 ADC_EN,
  input  logic [ADC_WIDTH-1:0] ADC_DATA,
  output logic                 ADC_DONE,
  output logic [ACC_WIDTH-1:0] J_SUM,
  output logic [ADC_WIDTH-1:0] J_MEAN,
  output logic                 OVERRANGE,
  output logic [1:0]           ADC_STATE
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SMP_W = SAMPLE_LOG2 + 1;
  localparam int CNT_W = (SET_W > SMP_W) ? SET_W : SMP_W;

  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SAMPLE_LAST =
    CNT_W'((1 << SAMPLE_LOG2) - 1);

  localparam logic [ADC_WIDTH-1:0] FS_MAX =
    {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic [ADC_WIDTH-1:0] FS_MIN =
    {1'b1, {(ADC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    ACCUM  = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]     cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 sticky;
  logic [ACC_WIDTH-1:0] j_sum;
  logic                 ovr;

  logic                 settle_end;
  logic                 accum_end;
  logic                 full_scale;
  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] acc_sum;

  assign settle_end = (cnt == SETTLE_LAST);
  assign accum_end  = (cnt == SAMPLE_LAST);
  assign full_scale = (ADC_DATA == FS_MAX) ||
                      (ADC_DATA == FS_MIN);
  assign sample_ext = ACC_WIDTH'($signed(ADC_DATA));
  assign acc_sum    = acc + sample_ext;

  // State register
  always_ff @(posedge ADC_CLK or negedge ADC_RSTN) begin
    if (!ADC_RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: dropping ADC_EN anywhere returns to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ADC_EN) begin
          state_nxt = (SETTLE_CYCLES == 0) ? ACCUM : SETTLE;
        end
      end
      SETTLE: begin
        if (!ADC_EN) begin
          state_nxt = IDLE;
        end else if (settle_end) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (!ADC_EN) begin
          state_nxt = IDLE;
        end else if (accum_end) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!ADC_EN) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter, accumulator and result capture; aborts simply leave
  // the partial sum behind, it is cleared on the next request
  always_ff @(posedge ADC_CLK or negedge ADC_RSTN) begin
    if (!ADC_RSTN) begin
      cnt    <= '0;
      acc    <= '0;
      sticky <= 1'b0;
      j_sum  <= '0;
      ovr    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ADC_EN) begin
            cnt    <= '0;
            acc    <= '0;
            sticky <= 1'b0;
          end
        end
        SETTLE: begin
          if (ADC_EN) begin
            cnt <= settle_end ? '0 : cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (ADC_EN) begin
            acc    <= acc_sum;
            sticky <= sticky | full_scale;
            cnt    <= cnt + 1'b1;
            if (accum_end) begin
              cnt   <= '0;
              j_sum <= acc_sum;
              ovr   <= sticky | full_scale;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ADC_DONE  = (state == DONE);
  assign ADC_STATE = state;
  assign J_SUM     = j_sum;
  assign OVERRANGE = ovr;
  assign J_MEAN    = ADC_WIDTH'($signed(j_sum) >>> SAMPLE_LOG2);

endmodule

// File: tb/tb_spgd_adc_integrator.sv
// tb_spgd_adc_integrator: randomized bench with a transaction-level model.
// Instance 0 uses defaults; instance 1 uses SETTLE_CYCLES=2, SAMPLE_LOG2=2.
module tb_spgd_adc_integrator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        en    [2];
  logic [13:0] dat   [2];
  logic        done  [2];
  logic [31:0] jsum  [2];
  logic [13:0] jmean [2];
  logic        ovr   [2];
  logic [1:0]  st    [2];

  int S_P [2] = '{10, 2};
  int L_P [2] = '{10, 2};

  int exp_sum [2];
  bit exp_ovr [2];

  int checks = 0;
  int errors = 0;
  int stim[$];

  spgd_adc_integrator u_dflt (
    .ADC_CLK   (clk),
    .ADC_RSTN  (rstn),
    .ADC_EN    (en[0]),
    .ADC_DATA  (dat[0]),
    .ADC_DONE  (done[0]),
    .J_SUM     (jsum[0]),
    .J_MEAN    (jmean[0]),
    .OVERRANGE (ovr[0]),
    .ADC_STATE (st[0])
  );

  spgd_adc_integrator #(
    .SETTLE_CYCLES (2),
    .SAMPLE_LOG2   (2)
  ) u_small (
    .ADC_CLK   (clk),
    .ADC_RSTN  (rstn),
    .ADC_EN    (en[1]),
    .ADC_DATA  (dat[1]),
    .ADC_DONE  (done[1]),
    .J_SUM     (jsum[1]),
    .J_MEAN    (jmean[1]),
    .OVERRANGE (ovr[1]),
    .ADC_STATE (st[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic chk_result(input int w, input string tag);
    logic [13:0] m;
    m = 14'(exp_sum[w] >>> L_P[w]);
    chk({tag, "_jsum"}, jsum[w], exp_sum[w]);
    chk({tag, "_jmean"}, 32'(jmean[w]), 32'(m));
    chk({tag, "_ovr"}, 32'(ovr[w]), 32'(exp_ovr[w]));
  endtask

  function automatic int total_of(input int w);
    return S_P[w] + (1 << L_P[w]);
  endfunction

  task automatic fill_const(input int w, input int v);
    stim.delete();
    for (int i = 0; i <= total_of(w) + 1; i++) stim.push_back(v);
  endtask

  task automatic fill_rand(input int w);
    int r;
    int v;
    stim.delete();
    for (int i = 0; i <= total_of(w) + 1; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) v = 8191;
      else if (r == 1) v = -8192;
      else v = int'($urandom_range(0, 16383)) - 8192;
      stim.push_back(v);
    end
  endtask

  // stim[e] is presented for the e-th edge after the request edge (e=0)
  task automatic capture(input int w, input int hold, input int abort_at);
    int  s;
    int  total;
    int  sum;
    bit  fs;
    s     = S_P[w];
    total = total_of(w);
    sum   = 0;
    fs    = 1'b0;
    for (int i = s + 1; i <= total; i++) begin
      sum += stim[i];
      if (stim[i] == 8191 || stim[i] == -8192) fs = 1'b1;
    end
    en[w] = 1'b1;
    for (int e = 0; e <= total; e++) begin
      dat[w] = 14'(stim[e]);
      if (e == abort_at) en[w] = 1'b0;
      @(posedge clk);
      #1;
      if (e == abort_at) begin
        chk("abort_st", 32'(st[w]), 0);
        chk("abort_done", 32'(done[w]), 0);
        chk_result(w, "abort");
        return;
      end
      if (e < total) begin
        chk("busy_done", 32'(done[w]), 0);
        chk("busy_st", 32'(st[w]), (e < s) ? 1 : 2);
        chk_result(w, "hold");
      end
    end
    exp_sum[w] = sum;
    exp_ovr[w] = fs;
    chk("done", 32'(done[w]), 1);
    chk("done_st", 32'(st[w]), 3);
    chk_result(w, "new");
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("held_done", 32'(done[w]), 1);
      chk("held_st", 32'(st[w]), 3);
    end
    en[w] = 1'b0;
    @(posedge clk);
    #1;
    chk("rearm_done", 32'(done[w]), 0);
    chk("rearm_st", 32'(st[w]), 0);
    chk_result(w, "drop");
  endtask

  task automatic chk_zero(input int w);
    chk("rst_done", 32'(done[w]), 0);
    chk("rst_jsum", jsum[w], 0);
    chk("rst_jmean", 32'(jmean[w]), 0);
    chk("rst_ovr", 32'(ovr[w]), 0);
    chk("rst_st", 32'(st[w]), 0);
  endtask

  initial begin
    int hold;
    int abort_at;
    rstn = 1'b0;
    for (int w = 0; w < 2; w++) begin
      en[w]      = 1'b0;
      dat[w]     = '0;
      exp_sum[w] = 0;
      exp_ovr[w] = 1'b0;
    end
    #12;
    chk_zero(0);
    chk_zero(1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    fill_const(0, 100);
    capture(0, 3, -1);

    stim = {0, 500, 500, -3, -5, -1, -7, 999};
    capture(1, 0, -1);
    stim = {0, 9, 9, -1, -2, -2, -2, 0};
    capture(1, 1, -1);

    fill_const(1, 100);
    capture(1, 0, -1);
    fill_const(1, 50);
    capture(1, 0, 4);

    stim = {0, 8191, 8191, 1, 2, 3, 4, 0};
    capture(1, 0, -1);
    stim = {0, 1, 1, 5, 5, 5, -8192, 0};
    capture(1, 2, -1);

    for (int n = 0; n < 30; n++) begin
      fill_rand(1);
      hold     = int'($urandom_range(0, 3));
      abort_at = -1;
      if ($urandom_range(0, 3) == 0)
        abort_at = int'($urandom_range(0, total_of(1)));
      capture(1, hold, abort_at);
    end

    fill_rand(0);
    capture(0, 1, -1);

    fill_rand(0);
    en[0] = 1'b1;
    for (int e = 0; e < S_P[0] + 6; e++) begin
      dat[0] = 14'(stim[e]);
      @(posedge clk);
      #1;
    end
    #2;
    rstn = 1'b0;
    #1;
    chk_zero(0);
    chk_zero(1);
    for (int w = 0; w < 2; w++) begin
      exp_sum[w] = 0;
      exp_ovr[w] = 1'b0;
    end
    en[0] = 1'b0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_result(0, "post_rst");
    fill_rand(0);
    capture(0, 0, -1);
    fill_rand(1);
    capture(1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
